dino_obstacle: RTL and testbench

Obstacle field and collision detector for the dino runner. Scrolls up to two obstacles leftward on the 100 Hz game tick, spawns new ones at pseudo-random gaps, keeps the score, and drives `kill` back into the dino controller when the dino's bounding box overlaps an obstacle. Sits between the dino controller (position/state source) and the VGA renderer (obstacle position consumer).

---
 rtl/dino_pkg.sv | 56 +++++
 rtl/lfsr16.sv | 29 ++
 rtl/dino_obstacle.sv | 259 +++++++++++++++++++++++++
 tb/tb_dino_obstacle.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the dino runner: dino_state encodings (shared with the
// dino controller and the VGA renderer), the obstacle FSM state enum, playfield
// geometry defaults, and a small box-overlap helper.
// Geometry constants are 11 bits wide so that "edge + width" never wraps when
// compared against 10-bit screen coordinates.
// -----------------------------------------------------------------------------
package dino_pkg;

  // dino_state encodings driven by the dino controller
  localparam logic [3:0] DS_STOP = 4'b0000;
  localparam logic [3:0] DS_RUN  = 4'b0001;
  localparam logic [3:0] DS_JUMP = 4'b0011;
  localparam logic [3:0] DS_DOWN = 4'b0010;
  localparam logic [3:0] DS_DIE  = 4'b0110;

  // Obstacle-field FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } obs_state_e;

  // Geometry (pixels)
  localparam logic [9:0]  SPAWN_X     = 10'd640;
  localparam logic [10:0] GROUND_Y    = 11'd443;
  localparam logic [10:0] DINO_W      = 11'd40;
  localparam logic [10:0] DINO_H      = 11'd43;
  localparam logic [10:0] DINO_DUCK_H = 11'd26;
  localparam logic [10:0] CACTUS_W    = 11'd20;
  localparam logic [10:0] CACTUS_H    = 11'd40;
  localparam logic [10:0] BIRD_Y      = 11'd380;
  localparam logic [10:0] BIRD_W      = 11'd30;
  localparam logic [10:0] BIRD_H      = 11'd30;

  // Pacing
  localparam logic [6:0]  GAP_MIN     = 7'd40;
  localparam logic [3:0]  SPEED_INIT  = 4'd4;
  localparam logic [3:0]  SPEED_MAX   = 4'd12;

  // Spawn randomiser
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;

  // Half-open box overlap: [ax0,ax1) x [ay0,ay1) against [bx0,bx1) x [by0,by1)
  function automatic logic box_hit(
    input logic [10:0] ax0, input logic [10:0] ax1,
    input logic [10:0] ay0, input logic [10:0] ay1,
    input logic [10:0] bx0, input logic [10:0] bx1,
    input logic [10:0] by0, input logic [10:0] by1
  );
    return (ax0 < bx1) && (bx0 < ax1) && (ay0 < by1) && (by0 < ay1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit right-shifting Galois LFSR (mask 16'hB400), advancing every clock.
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset, loads SEED
//   state  out : current 16-bit LFSR state
// Parameter:
//   SEED       : reset value (must be nonzero)
// -----------------------------------------------------------------------------
module lfsr16
  import dino_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/dino_obstacle.sv
// -----------------------------------------------------------------------------
// dino_obstacle
// Obstacle field and collision detector for the dino runner. Scrolls up to two
// obstacles leftward on each 100 Hz tick, spawns new ones after pseudo-random
// gaps, keeps the score/speed, and raises a sticky kill on dino/obstacle
// overlap.
//
// Build option: define DINO_OBSTACLE_BIRD_EN to enable bird obstacles (spawn
// type taken from lfsr[7], bird boxes collide). Without it every obstacle is a
// cactus and obs_type is tied to 0.
//
// Handshake/timing: tick_100Hz is a one-cycle enable; start is a level. There
// is no backpressure -- every registered output changes on the clock edge
// after the cycle that caused it, and kill follows the overlap by one cycle.
//
// Ports:
//   clk_25MHz  in      : clock
//   rst_n      in      : asynchronous active-low reset
//   tick_100Hz in      : game tick enable
//   start      in      : start / restart request
//   dino_x     in [9:0]: dino left edge
//   dino_y     in [8:0]: dino top edge when standing
//   dino_state in [3:0]: dino controller state (dino_pkg DS_*)
//   kill       out     : registered collision flag, sticky until restart
//   score      out[15:0]: ticks survived, saturating
//   speed      out[3:0]: pixels per tick
//   obs_valid  out[1:0]: slot occupied
//   obs0_x     out[9:0]: slot 0 left edge
//   obs1_x     out[9:0]: slot 1 left edge
//   obs_type   out[1:0]: 0 = cactus, 1 = bird
//   state_dbg  out[1:0]: current FSM state (obs_state_e encoding)
// -----------------------------------------------------------------------------
module dino_obstacle
  import dino_pkg::*;
(
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        tick_100Hz,
  input  logic        start,
  input  logic [9:0]  dino_x,
  input  logic [8:0]  dino_y,
  input  logic [3:0]  dino_state,
  output logic        kill,
  output logic [15:0] score,
  output logic [3:0]  speed,
  output logic [1:0]  obs_valid,
  output logic [9:0]  obs0_x,
  output logic [9:0]  obs1_x,
  output logic [1:0]  obs_type,
  output logic [1:0]  state_dbg
);

  obs_state_e        state, state_nxt;
  logic              hit;
  logic              enter_run, run_tick, kill_nxt;

  logic [15:0]       lfsr;
  logic              lfsr_unused;

  logic [1:0][9:0]   obs_x_q, x_nxt;
  logic [1:0]        valid_nxt;
  logic [6:0]        gap_q, gap_dec, gap_nxt;
  logic [15:0]       score_nxt;
  logic [6:0]        spd_sum;
  logic [3:0]        speed_nxt;
  logic [1:0]        hit_vec;
  logic [10:0]       dx0, dx1, dy0, dy1;

`ifdef DINO_OBSTACLE_BIRD_EN
  logic [1:0]        bird_q, bird_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Free-running spawn randomiser
  // ---------------------------------------------------------------------------
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .state (lfsr)
  );

  // Only the low byte feeds spawn decisions.
  assign lfsr_unused = ^lfsr[15:6];

  // ---------------------------------------------------------------------------
  // Collision (combinational, from registered obstacles and live dino inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    dx0 = {1'b0, dino_x};
    dx1 = dx0 + DINO_W;
    dy1 = {2'b00, dino_y} + DINO_H;
    // Ducking keeps the bottom edge and lowers the top edge.
    dy0 = (dino_state == DS_DOWN) ? ({2'b00, dino_y} + (DINO_H - DINO_DUCK_H))
                                  : {2'b00, dino_y};
  end

  always_comb begin
    hit_vec = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (obs_valid[i] && (dino_state != DS_STOP)) begin
`ifdef DINO_OBSTACLE_BIRD_EN
        if (bird_q[i]) begin
          hit_vec[i] = box_hit(dx0, dx1, dy0, dy1,
                               {1'b0, obs_x_q[i]}, {1'b0, obs_x_q[i]} + BIRD_W,
                               BIRD_Y, BIRD_Y + BIRD_H);
        end else begin
          hit_vec[i] = box_hit(dx0, dx1, dy0, dy1,
                               {1'b0, obs_x_q[i]}, {1'b0, obs_x_q[i]} + CACTUS_W,
                               GROUND_Y - CACTUS_H, GROUND_Y);
        end
`else
        hit_vec[i] = box_hit(dx0, dx1, dy0, dy1,
                             {1'b0, obs_x_q[i]}, {1'b0, obs_x_q[i]} + CACTUS_W,
                             GROUND_Y - CACTUS_H, GROUND_Y);
`endif
      end
    end
  end

  assign hit = |hit_vec;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (hit)   state_nxt = ST_HIT;
      ST_HIT:  if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (datapath controls). A tick coinciding with an overlap is
  // dropped so the frozen field shows the positions that caused the hit.
  always_comb begin
    enter_run = 1'b0;
    run_tick  = 1'b0;
    kill_nxt  = 1'b0;
    case (state)
      ST_IDLE: enter_run = start;
      ST_RUN: begin
        kill_nxt = hit;
        run_tick = tick_100Hz && !hit;
      end
      ST_HIT: begin
        enter_run = start;
        kill_nxt  = !start;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Tick update: move, then spawn into what is free after the move, then score
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_nxt = obs_valid;
    x_nxt     = obs_x_q;
`ifdef DINO_OBSTACLE_BIRD_EN
    bird_nxt  = bird_q;
`endif
    for (int i = 0; i < 2; i++) begin
      if (obs_valid[i]) begin
        // Retire instead of subtracting so a slot never wraps to ~1023.
        if (obs_x_q[i] < {6'd0, speed}) begin
          valid_nxt[i] = 1'b0;
        end else begin
          x_nxt[i] = obs_x_q[i] - {6'd0, speed};
        end
      end
    end

    // The counter reaching zero on this tick (or already parked at zero with
    // both slots busy) triggers a spawn attempt.
    gap_dec = (gap_q != 7'd0) ? (gap_q - 7'd1) : 7'd0;
    gap_nxt = gap_dec;
    if (gap_dec == 7'd0) begin
      if (!valid_nxt[0]) begin
        valid_nxt[0] = 1'b1;
        x_nxt[0]     = SPAWN_X;
`ifdef DINO_OBSTACLE_BIRD_EN
        bird_nxt[0]  = lfsr[7];
`endif
        gap_nxt      = GAP_MIN + {1'b0, lfsr[5:0]};
      end else if (!valid_nxt[1]) begin
        valid_nxt[1] = 1'b1;
        x_nxt[1]     = SPAWN_X;
`ifdef DINO_OBSTACLE_BIRD_EN
        bird_nxt[1]  = lfsr[7];
`endif
        gap_nxt      = GAP_MIN + {1'b0, lfsr[5:0]};
      end
    end

    score_nxt = (&score) ? score : (score + 16'd1);
    spd_sum   = {3'b000, SPEED_INIT} + {1'b0, score_nxt[15:10]};
    speed_nxt = (spd_sum > {3'b000, SPEED_MAX}) ? SPEED_MAX : spd_sum[3:0];
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      kill      <= 1'b0;
      score     <= 16'd0;
      speed     <= SPEED_INIT;
      obs_valid <= 2'b00;
      obs_x_q   <= '0;
      gap_q     <= GAP_MIN;
    end else begin
      kill <= kill_nxt;
      if (enter_run) begin
        // Restart: empty field, fresh score/speed, full initial gap.
        obs_valid <= 2'b00;
        score     <= 16'd0;
        speed     <= SPEED_INIT;
        gap_q     <= GAP_MIN;
      end else if (run_tick) begin
        obs_valid <= valid_nxt;
        obs_x_q   <= x_nxt;
        gap_q     <= gap_nxt;
        score     <= score_nxt;
        speed     <= speed_nxt;
      end
    end
  end

`ifdef DINO_OBSTACLE_BIRD_EN
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      bird_q <= 2'b00;
    end else if (run_tick && !enter_run) begin
      bird_q <= bird_nxt;
    end
  end

  assign obs_type = bird_q;
`else
  assign obs_type = 2'b00;
`endif

  assign obs0_x = obs_x_q[0];
  assign obs1_x = obs_x_q[1];

endmodule

// File: tb/tb_dino_obstacle.sv
// -----------------------------------------------------------------------------
// tb_dino_obstacle
// Self-checking bench for dino_obstacle. A behavioural model (integer
// geometry, per-obstacle arrays) predicts every registered output each cycle;
// predictions go through an expected queue and are compared after the edge.
// Directed phases cover spawn timing, collision latency, restart, speed step
// and asynchronous reset; a randomized phase mixes ticks, restarts and dino
// positions. Honour DINO_OBSTACLE_BIRD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dino_obstacle;

`ifdef DINO_OBSTACLE_BIRD_EN
  localparam bit BIRD_EN = 1'b1;
`else
  localparam bit BIRD_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk_25MHz  = 1'b0;
  logic        rst_n      = 1'b1;
  logic        tick_100Hz = 1'b0;
  logic        start      = 1'b0;
  logic [9:0]  dino_x     = '0;
  logic [8:0]  dino_y     = '0;
  logic [3:0]  dino_state = '0;
  logic        kill;
  logic [15:0] score;
  logic [3:0]  speed;
  logic [1:0]  obs_valid;
  logic [9:0]  obs0_x, obs1_x;
  logic [1:0]  obs_type;
  logic [1:0]  state_dbg;

  always #20 clk_25MHz = ~clk_25MHz;

  dino_obstacle dut (
    .clk_25MHz  (clk_25MHz),
    .rst_n      (rst_n),
    .tick_100Hz (tick_100Hz),
    .start      (start),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .dino_state (dino_state),
    .kill       (kill),
    .score      (score),
    .speed      (speed),
    .obs_valid  (obs_valid),
    .obs0_x     (obs0_x),
    .obs1_x     (obs1_x),
    .obs_type   (obs_type),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [44:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_mode;
  bit          m_kill;
  int          m_score, m_speed, m_gap;
  bit          m_valid[2];
  int          m_x[2];
  bit          m_bird[2];
  bit [15:0]   m_lfsr;

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_kill  = 1'b0;
    m_score = 0;
    m_speed = 4;
    m_gap   = 40;
    m_lfsr  = 16'hACE1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_x[i]     = 0;
      m_bird[i]  = 1'b0;
    end
  endfunction

  function automatic bit [15:0] lfsr_step(input bit [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit spans(input int a0, input int a1, input int b0, input int b1);
    return (a0 < b1) && (b0 < a1);
  endfunction

  function automatic bit model_collide();
    int l, r, top, bot;
    if (dino_state == 4'b0000) return 1'b0;
    l   = int'(dino_x);
    r   = l + 40;
    bot = int'(dino_y) + 43;
    top = (dino_state == 4'b0010) ? bot - 26 : int'(dino_y);
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        if (m_bird[i]) begin
          if (spans(l, r, m_x[i], m_x[i] + 30) && spans(top, bot, 380, 410)) return 1'b1;
        end else begin
          if (spans(l, r, m_x[i], m_x[i] + 20) && spans(top, bot, 403, 443)) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic void model_tick(input bit [15:0] l);
    int slot;
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        if (m_x[i] < m_speed) m_valid[i] = 1'b0;
        else m_x[i] = m_x[i] - m_speed;
      end
    end
    if (m_gap > 0) m_gap--;
    if (m_gap == 0) begin
      slot = !m_valid[0] ? 0 : (!m_valid[1] ? 1 : -1);
      if (slot >= 0) begin
        m_valid[slot] = 1'b1;
        m_x[slot]     = 640;
        m_bird[slot]  = BIRD_EN ? l[7] : 1'b0;
        m_gap         = 40 + int'(l[5:0]);
      end
    end
    if (m_score < 65535) m_score++;
    m_speed = 4 + m_score / 1024;
    if (m_speed > 12) m_speed = 12;
  endfunction

  function automatic void model_step(input bit tk, input bit st);
    bit [15:0] l;
    l      = m_lfsr;
    m_lfsr = lfsr_step(m_lfsr);
    if (m_mode == M_RUN) begin
      if (model_collide()) begin
        m_mode = M_HIT;
        m_kill = 1'b1;
      end else if (tk) begin
        model_tick(l);
      end
    end else if (st) begin
      m_mode     = M_RUN;
      m_kill     = 1'b0;
      m_score    = 0;
      m_speed    = 4;
      m_gap      = 40;
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
    end
    exp_q.push_back({m_kill, m_score[15:0], m_speed[3:0], m_valid[1], m_valid[0],
                     m_x[0][9:0], m_x[1][9:0], m_bird[1], m_bird[0]});
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle with the given tick/start, then compare
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit tk, input bit st);
    logic [44:0] e;
    tick_100Hz = tk;
    start      = st;
    model_step(tk, st);
    @(posedge clk_25MHz);
    #1;
    tick_100Hz = 1'b0;
    start      = 1'b0;
    e = exp_q.pop_front();
    check("kill",      kill,      e[44]);
    check("score",     score,     e[43:28]);
    check("speed",     speed,     e[27:24]);
    check("obs_valid", obs_valid, e[23:22]);
    check("obs0_x",    obs0_x,    e[21:12]);
    check("obs1_x",    obs1_x,    e[11:2]);
    check("obs_type",  obs_type,  e[1:0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_kill"},  kill,      0);
    check({tag, "_score"}, score,     0);
    check({tag, "_speed"}, speed,     4);
    check({tag, "_valid"}, obs_valid, 0);
    check({tag, "_x0"},    obs0_x,    0);
    check({tag, "_x1"},    obs1_x,    0);
    check({tag, "_type"},  obs_type,  0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] ds_tab [6];
  logic [9:0] x_at;
  logic [15:0] s_at;

  initial begin
    ds_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0101};
    model_reset();

    // Reset between edges
    #5 rst_n = 1'b0;
    #2 check_reset_values("rst");
    #43 rst_n = 1'b1;

    // Spawn timing: start, 40 ticks -> spawn at 640; 5 more -> 620
    dino_state = 4'b0000;
    dino_x     = 10'd50;
    dino_y     = 9'd400;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
    check("spawn_valid0", obs_valid[0], 1);
    check("spawn_x",      obs0_x,       640);
    check("spawn_score",  score,        40);
    if (!BIRD_EN) check("spawn_type", obs_type[0], 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check("scroll_x",     obs0_x, 620);
    check("scroll_score", score,  45);

    // Collision: standing dino at x=50; kill one cycle after obs0_x <= 89
    dino_state = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      if (kill) break;
      if (obs_valid[0] && (obs0_x <= 10'd89)) begin
        x_at = obs0_x;
        s_at = score;
        cycle(1'b1, 1'b0);
        check("kill_latency",  kill,   1);
        check("hit_freeze_x",  obs0_x, x_at);
        check("hit_freeze_sc", score,  s_at);
        check("hit_x_bound",   x_at,   (x_at <= 10'd89) ? x_at : 10'd89);
        break;
      end
      cycle(1'b1, 1'b0);
    end
    check("kill_reached", kill, 1);
    s_at = score;

    // HIT holds everything through ticks
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    check("hit_hold_score", score, s_at);
    check("hit_hold_kill",  kill,  1);

    // Restart from HIT
    cycle(1'b0, 1'b1);
    check("restart_kill",  kill,      0);
    check("restart_valid", obs_valid, 0);
    check("restart_score", score,     0);
    check("restart_speed", speed,     4);

    // Long run without collision: speed steps to 5 after score 1024, and
    // slots retire rather than wrapping once x drops below the speed
    dino_state = 4'b0000;
    for (int i = 0; i < 1200; i++) cycle(1'b1, 1'b0);
    check("speed_step", speed, 5);
    check("long_score", score, 1200);

    // Randomized mix of ticks, restarts, dino positions and states
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        dino_x     = 10'($urandom_range(0, 700));
        dino_y     = 9'($urandom_range(340, 440));
        dino_state = ds_tab[$urandom_range(0, 5)];
      end
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-game
    dino_state = 4'b0000;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0);
    #5 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(posedge clk_25MHz);
    #1;
    check("rst_hold_kill",  kill,  0);
    check("rst_hold_score", score, 0);
    #5 rst_n = 1'b1;
    cycle(1'b1, 1'b0);             // first edge after release: IDLE, tick ignored
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
